// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC output-port arbiter.
package noc_arb_pkg;

    localparam int NUM_PORTS_DEF = 5;
    localparam int PORT_ID_W     = 3;

    localparam logic [PORT_ID_W-1:0] PORT_N = 3'd0;
    localparam logic [PORT_ID_W-1:0] PORT_S = 3'd1;
    localparam logic [PORT_ID_W-1:0] PORT_E = 3'd2;
    localparam logic [PORT_ID_W-1:0] PORT_W = 3'd3;
    localparam logic [PORT_ID_W-1:0] PORT_L = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_port_arbiter_if.sv
// Request/grant and next-hop-register signals between input ports and one output-port arbiter.
interface rr_port_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF
) ();

    logic [NUM_PORTS-1:0] req_i;
    logic                 out_ready_i;
    logic                 pt_almost_done_i;
    logic [NUM_PORTS-1:0] grant_o;
    logic                 grant_valid_o;
    logic                 nhr_write_o;
    logic [PORT_ID_W-1:0] nhr_address_o;
    logic                 timeout_o;

    modport master (
        output req_i, out_ready_i, pt_almost_done_i,
        input  grant_o, grant_valid_o, nhr_write_o, nhr_address_o, timeout_o
    );

    modport slave (
        input  req_i, out_ready_i, pt_almost_done_i,
        output grant_o, grant_valid_o, nhr_write_o, nhr_address_o, timeout_o
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Zero latency; valid_o low when no request is set.
module rr_priority_picker
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_ID_W-1:0] ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PORT_ID_W-1:0] id_o,
    output logic                 valid_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // Subtract instead of modulo so non-power-of-two port counts wrap cleanly.
            idx = int'(ptr_i) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = PORT_ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin output-port arbiter: grants one input per packet, 1-cycle registered grant latency.
// Arbitrates only when out_ready_i is high; releases on last flit, request drop or hold timeout.
module rr_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int MAX_HOLD  = 16
) (
    input  logic               clk,
    input  logic               reset,
    rr_port_arbiter_if.slave   bus
);

    localparam int HCW = $clog2(MAX_HOLD);

    arb_state_t           state_q,    state_d;
    logic [PORT_ID_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [PORT_ID_W-1:0] winner_q,   winner_d;
    logic [NUM_PORTS-1:0] grant_q,    grant_d;
    logic                 nhr_write_q, nhr_write_d;
    logic [PORT_ID_W-1:0] nhr_addr_q, nhr_addr_d;
    logic                 timeout_q,  timeout_d;

    logic [NUM_PORTS-1:0] pick_grant;
    logic [PORT_ID_W-1:0] pick_id;
    logic                 pick_vld;
    logic                 win_req;
    logic                 hold_hit;
    logic                 release_now;

    rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req_i   (bus.req_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .id_o    (pick_id),
        .valid_o (pick_vld)
    );

    assign win_req     = bus.req_i[winner_q];
    assign hold_hit    = (hold_cnt_q == HCW'(MAX_HOLD - 1));
    assign release_now = bus.pt_almost_done_i || !win_req || hold_hit;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        winner_d    = winner_q;
        grant_d     = grant_q;
        nhr_write_d = 1'b0;
        nhr_addr_d  = nhr_addr_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld && bus.out_ready_i) begin
                    state_d     = BUSY;
                    winner_d    = pick_id;
                    grant_d     = pick_grant;
                    hold_cnt_d  = '0;
                    nhr_write_d = 1'b1;
                    nhr_addr_d  = pick_id;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    hold_cnt_d  = '0;
                    nhr_write_d = 1'b1;
                    nhr_addr_d  = PORT_N;
                    rr_ptr_d    = (winner_q == PORT_ID_W'(NUM_PORTS - 1)) ? PORT_N
                                                                          : winner_q + 1'b1;
                    // A last flit landing on the limit cycle is a normal release.
                    timeout_d   = hold_hit && win_req && !bus.pt_almost_done_i;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PORT_N;
            hold_cnt_q  <= '0;
            winner_q    <= PORT_N;
            grant_q     <= '0;
            nhr_write_q <= 1'b0;
            nhr_addr_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            winner_q    <= winner_d;
            grant_q     <= grant_d;
            nhr_write_q <= nhr_write_d;
            nhr_addr_q  <= nhr_addr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = |grant_q;
    assign bus.nhr_write_o   = nhr_write_q;
    assign bus.nhr_address_o = nhr_addr_q;
    assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed scenarios followed by randomized traffic, checked cycle by cycle against a packet-level model.
module tb_rr_port_arbiter;

    localparam int NP   = 5;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    rr_port_arbiter_if #(.NUM_PORTS(NP)) bus ();

    rr_port_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: packet-level view of the arbiter.
    bit          m_busy;
    int          m_win, m_ptr, m_hold;
    logic [4:0]  e_grant;
    logic        e_wr, e_to;
    logic [2:0]  e_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [4:0] req, input logic rdy, input logic done);
        if (rst) begin
            m_busy = 0; m_win = 0; m_ptr = 0; m_hold = 0;
            e_grant = '0; e_wr = 0; e_to = 0; e_addr = '0;
            return;
        end
        e_wr = 0;
        e_to = 0;
        if (!m_busy) begin
            if (req != 0 && rdy) begin
                for (int k = NP - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % NP]) m_win = (m_ptr + k) % NP;
                m_busy  = 1;
                m_hold  = 0;
                e_grant = 5'(1 << m_win);
                e_wr    = 1;
                e_addr  = 3'(m_win);
            end
        end else if (done || !req[m_win] || m_hold == HOLD - 1) begin
            e_to    = !done && req[m_win] && (m_hold == HOLD - 1);
            m_busy  = 0;
            m_ptr   = (m_win + 1) % NP;
            e_grant = '0;
            e_wr    = 1;
            e_addr  = '0;
        end else begin
            m_hold++;
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] req, input logic rdy, input logic done);
        @(negedge clk);
        reset              = rst;
        bus.req_i          = req;
        bus.out_ready_i    = rdy;
        bus.pt_almost_done_i = done;
        @(posedge clk);
        model_edge(rst, req, rdy, done);
        #1;
        chk("grant",       32'(bus.grant_o),       32'(e_grant));
        chk("grant_valid", 32'(bus.grant_valid_o), 32'(|e_grant));
        chk("nhr_write",   32'(bus.nhr_write_o),   32'(e_wr));
        chk("nhr_address", 32'(bus.nhr_address_o), 32'(e_addr));
        chk("timeout",     32'(bus.timeout_o),     32'(e_to));
    endtask

    initial begin
        int to_cnt, g_cnt;
        logic [4:0] rq;
        reset = 1'b1;
        bus.req_i = '0;
        bus.out_ready_i = 1'b0;
        bus.pt_almost_done_i = 1'b0;

        // Reset state.
        step(1, 5'b00000, 0, 0);
        step(1, 5'b11111, 1, 0);
        chk("reset_grant", 32'(bus.grant_o), 32'd0);

        // Single request from port E.
        step(0, 5'b00100, 1, 0);
        chk("first_grant", 32'(bus.grant_o), 32'b00100);
        chk("first_addr",  32'(bus.nhr_address_o), 32'd2);
        step(0, 5'b00100, 1, 1);
        step(0, 5'b00000, 1, 0);

        // Full rotation from pointer 0 with all ports requesting.
        step(1, 5'b00000, 0, 0);
        for (int p = 0; p < 6; p++) begin
            step(0, 5'b11111, 1, 0);
            chk("rotate_grant", 32'(bus.grant_o), 32'(1 << (p % NP)));
            step(0, 5'b11111, 1, 0);
            step(0, 5'b11111, 1, 0);
            step(0, 5'b11111, 1, 1);
            chk("rotate_bubble", 32'(bus.grant_o), 32'd0);
        end
        step(0, 5'b00000, 1, 0);

        // Port L wins, pointer wraps to 0.
        step(0, 5'b10000, 1, 0);
        chk("wrap_grant4", 32'(bus.grant_o), 32'b10000);
        step(0, 5'b10000, 1, 1);
        step(0, 5'b10001, 1, 0);
        chk("wrap_grant0", 32'(bus.grant_o), 32'b00001);
        step(0, 5'b10001, 1, 1);
        step(0, 5'b00000, 1, 0);

        // Forced release after the hold limit.
        to_cnt = 0; g_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            step(0, 5'b00010, (c == 0), 0);
            if (bus.grant_valid_o) g_cnt++;
            if (bus.timeout_o) to_cnt++;
            if (c == 16) chk("timeout_addr_zero", 32'(bus.nhr_address_o), 32'd0);
            if (c == 17) break;
        end
        chk("timeout_pulses", 32'(to_cnt), 32'd1);
        chk("hold_cycles",    32'(g_cnt),  32'd16);
        step(0, 5'b00000, 1, 0);

        // Abort by request drop, then reset during BUSY.
        step(0, 5'b00100, 1, 0);
        step(0, 5'b00100, 1, 0);
        step(0, 5'b00000, 1, 0);
        chk("abort_grant", 32'(bus.grant_o), 32'd0);
        chk("abort_to",    32'(bus.timeout_o), 32'd0);
        step(0, 5'b01000, 1, 0);
        step(0, 5'b01000, 1, 0);
        step(1, 5'b01000, 1, 0);
        chk("rst_busy_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_busy_wr",    32'(bus.nhr_write_o), 32'd0);

        // Downstream stall.
        for (int c = 0; c < 5; c++) begin
            step(0, 5'b01000, 0, 0);
            chk("stall_grant", 32'(bus.grant_o), 32'd0);
        end
        step(0, 5'b01000, 1, 0);
        chk("unstall_grant", 32'(bus.grant_o), 32'b01000);
        step(0, 5'b01000, 1, 1);

        // Randomized traffic with sticky requests so timeouts also occur.
        rq = 5'b10101;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) rq = 5'($urandom);
            step(($urandom_range(299) == 0), rq, ($urandom_range(4) != 0),
                 ($urandom_range(24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
